// File: rtl/bar_ram_bridge.sv
// Bar-height write responder for the software PIO handshake. Heights go into a
// double-buffered memory; buffers swap at frame sync and the display reads the front one.
module bar_ram_bridge #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 6
) (
  input  logic              clk_clk,
  input  logic              reset_reset_n,
  input  logic [ADDR_W-1:0] ram_wraddress,
  input  logic [DATA_W-1:0] ram_data,
  input  logic              ram_wren,
  output logic              data_back,
  input  logic              frame_sync,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              swap_pending,
  output logic              front_sel
);

  typedef enum logic [1:0] {IDLE, STALL, WRITE, ACK} state_t;

  state_t            state, state_nxt;
  logic              latch;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic              do_swap;
  logic              last_wr;

  // Both buffers share one array; the MSB of the index selects the buffer.
  logic [DATA_W-1:0] mem [0:2**(ADDR_W+1)-1];

  assign do_swap = frame_sync && swap_pending;
  assign last_wr = (state == WRITE) && (addr_q == {ADDR_W{1'b1}});

  always_comb begin
    state_nxt = state;
    latch     = 1'b0;
    unique case (state)
      IDLE: if (ram_wren) begin
        latch     = 1'b1;
        state_nxt = swap_pending ? STALL : WRITE;
      end
      // Leaving on the swap edge itself lets the write land one cycle later.
      STALL: if (!swap_pending || do_swap) state_nxt = WRITE;
      WRITE: state_nxt = ACK;
      ACK:   if (!ram_wren) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      state        <= IDLE;
      addr_q       <= '0;
      data_q       <= '0;
      data_back    <= 1'b0;
      swap_pending <= 1'b0;
      front_sel    <= 1'b0;
      rd_data      <= '0;
    end else begin
      state     <= state_nxt;
      data_back <= (state == ACK);
      if (latch) begin
        addr_q <= ram_wraddress;
        data_q <= ram_data;
      end
      if (do_swap) begin
        front_sel    <= ~front_sel;
        swap_pending <= 1'b0;
      end else if (last_wr) begin
        swap_pending <= 1'b1;
      end
      rd_data <= mem[{front_sel, rd_addr}];
    end
  end

  // Memory is not reset; a reset edge during WRITE suppresses the store.
  always_ff @(posedge clk_clk) begin
    if (reset_reset_n && state == WRITE) mem[{~front_sel, addr_q}] <= data_q;
  end

endmodule

// File: tb/tb_bar_ram_bridge.sv
// Directed/random bench for bar_ram_bridge with a transaction-level buffer model.
module tb_bar_ram_bridge;

  logic       clk = 1'b0;
  logic       reset_reset_n;
  logic [5:0] ram_wraddress;
  logic [5:0] ram_data;
  logic       ram_wren;
  logic       data_back;
  logic       frame_sync;
  logic [5:0] rd_addr;
  logic [5:0] rd_data;
  logic       swap_pending;
  logic       front_sel;

  int checks = 0;
  int failures = 0;

  // Model: two buffers of heights, valid flags, displayed index, pending flag.
  int  bufm [2][64];
  bit  vld  [2][64];
  bit  m_front = 1'b0;
  bit  m_pend  = 1'b0;

  bar_ram_bridge #(.ADDR_W(6), .DATA_W(6)) dut (
    .clk_clk(clk), .reset_reset_n(reset_reset_n),
    .ram_wraddress(ram_wraddress), .ram_data(ram_data), .ram_wren(ram_wren),
    .data_back(data_back), .frame_sync(frame_sync),
    .rd_addr(rd_addr), .rd_data(rd_data),
    .swap_pending(swap_pending), .front_sel(front_sel)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic void model_fsync();
    if (m_pend) begin
      m_front = ~m_front;
      m_pend  = 1'b0;
    end
  endfunction

  function automatic void model_write(input int a, input int d);
    bufm[~m_front][a] = d;
    vld[~m_front][a]  = 1'b1;
    if (a == 63) m_pend = 1'b1;
  endfunction

  // One full handshake. fs raises frame_sync during the WRITE cycle;
  // hold keeps wren high that many cycles after the acknowledge.
  task automatic do_write(input int a, input int d, input bit fs, input int hold,
                          output int lat, output int rel);
    bit hold_ok = 1'b1;
    ram_wraddress = 6'(a);
    ram_data      = 6'(d);
    ram_wren      = 1'b1;
    lat = 0;
    for (int n = 1; n <= 40; n++) begin
      if (fs && n == 2) frame_sync = 1'b1;
      step();
      frame_sync = 1'b0;
      if (fs && n == 2) begin
        model_fsync();
        model_write(a, d);
        chk("simul_pending", swap_pending, 1);
        chk("simul_front", front_sel, m_front);
      end
      if (data_back) begin lat = n; break; end
    end
    chk("ack_seen", data_back, 1);
    if (!fs) model_write(a, d);
    if (hold > 0) begin
      for (int n = 0; n < hold; n++) begin
        ram_data = 6'($urandom);
        step();
        if (!data_back) hold_ok = 1'b0;
      end
      chk("held_ack", hold_ok, 1);
    end
    ram_wren = 1'b0;
    rel = 0;
    for (int n = 1; n <= 40; n++) begin
      step();
      if (!data_back) begin rel = n; break; end
    end
    chk("ack_released", data_back, 0);
  endtask

  task automatic pulse_fsync(input string tag);
    int  a = $urandom_range(0, 63);
    bit  ok = vld[m_front][a];
    int  e = bufm[m_front][a];
    rd_addr    = 6'(a);
    frame_sync = 1'b1;
    step();
    frame_sync = 1'b0;
    model_fsync();
    if (ok) chk({tag, "_edge_read"}, rd_data, e);
    chk({tag, "_front"}, front_sel, m_front);
    chk({tag, "_pending"}, swap_pending, m_pend);
  endtask

  task automatic rd_check(input string tag, input int a);
    rd_addr = 6'(a);
    step();
    chk(tag, rd_data, bufm[m_front][a]);
  endtask

  initial begin
    int lat, rel, d;
    reset_reset_n = 1'b0;
    ram_wraddress = '0;
    ram_data      = '0;
    ram_wren      = 1'b1;
    frame_sync    = 1'b0;
    rd_addr       = '0;
    step(); step();
    ram_wren = 1'b0;
    step();
    chk("rst_data_back", data_back, 0);
    chk("rst_pending", swap_pending, 0);
    chk("rst_front", front_sel, 0);
    chk("rst_rd_data", rd_data, 0);
    reset_reset_n = 1'b1;

    // Single handshake latency.
    do_write(5, 6'h2A, 1'b0, 0, lat, rel);
    chk("single_ack_lat", lat, 3);
    chk("single_rel_lat", rel, 2);
    chk("single_pending", swap_pending, 0);

    // A frame_sync with nothing pending is ignored.
    pulse_fsync("idle_fsync");

    // Frame A: height = address.
    for (int i = 0; i < 64; i++) begin
      do_write(i, i & 'h3F, 1'b0, 0, lat, rel);
      if (i == 62) chk("pending_before_last", swap_pending, 0);
    end
    chk("frameA_pending", swap_pending, 1);
    pulse_fsync("swapA");
    rd_check("read_addr10", 10);
    for (int k = 0; k < 4; k++) rd_check("rand_read_A", $urandom_range(0, 63));

    // Frame B: random heights into the other buffer.
    for (int i = 0; i < 64; i++) do_write(i, $urandom_range(0, 63), 1'b0, 0, lat, rel);
    chk("frameB_pending", swap_pending, 1);

    // Stall: write held off until the swap, then lands in the new back buffer.
    ram_wraddress = 6'd0;
    ram_data      = 6'h11;
    ram_wren      = 1'b1;
    lat = 0;
    for (int n = 0; n < 20; n++) begin
      step();
      if (data_back) lat++;
    end
    chk("stall_no_ack", lat, 0);
    frame_sync = 1'b1;
    step();
    frame_sync = 1'b0;
    model_fsync();
    chk("stall_swap_front", front_sel, m_front);
    chk("stall_swap_pending", swap_pending, 0);
    step();
    chk("stall_ack_early", data_back, 0);
    step();
    chk("stall_ack", data_back, 1);
    model_write(0, 'h11);
    ram_wren = 1'b0;
    step(); step();
    chk("stall_release", data_back, 0);
    rd_check("stall_front_addr0", 0);

    // Simultaneous: last-address WRITE coincides with frame_sync while idle.
    for (int i = 1; i < 63; i++) do_write(i, $urandom_range(0, 63), 1'b0, 0, lat, rel);
    do_write(63, $urandom_range(0, 63), 1'b1, 0, lat, rel);
    pulse_fsync("swapC");
    rd_check("stalled_word_visible", 0);
    for (int k = 0; k < 4; k++) rd_check("rand_read_C", $urandom_range(0, 63));

    // Held wren: one write of the originally latched data only.
    do_write(7, 6'h2D, 1'b0, 50, lat, rel);
    d = $urandom_range(0, 63);
    do_write(63, d, 1'b0, 0, lat, rel);
    pulse_fsync("swapD");
    rd_check("held_data", 7);
    rd_check("held_last", 63);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
